muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Sequences an external multiplier/divider pair and captures
//            results into the architectural Hi/Lo registers.
// Options  : MULDIV_DIV_ZERO_CHECK_EN - abort a divide whose divisor is zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] opnd_a,
    output logic [31:0] opnd_b,
    output logic        mult_rst,
    output logic        div_rst,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [5:0] MULT_CNT = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_CNT  = 6'(DIV_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DZERO   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [31:0] opnd_a_q, opnd_a_d;
    logic [31:0] opnd_b_q, opnd_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        mult_rst_q, mult_rst_d;
    logic        div_rst_q, div_rst_d;
`ifdef MULDIV_DIV_ZERO_CHECK_EN
    logic        dz_q, dz_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            op_q       <= 1'b0;
            opnd_a_q   <= 32'd0;
            opnd_b_q   <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            mult_rst_q <= 1'b1;
            div_rst_q  <= 1'b1;
`ifdef MULDIV_DIV_ZERO_CHECK_EN
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opnd_a_q   <= opnd_a_d;
            opnd_b_q   <= opnd_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            mult_rst_q <= mult_rst_d;
            div_rst_q  <= div_rst_d;
`ifdef MULDIV_DIV_ZERO_CHECK_EN
            dz_q       <= dz_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_a_d   = opnd_a_q;
        opnd_b_d   = opnd_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        mult_rst_d = 1'b0;
        div_rst_d  = 1'b0;
`ifdef MULDIV_DIV_ZERO_CHECK_EN
        dz_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Multiply wins when both requests arrive together.
                if (start_mult || start_div) begin
                    opnd_a_d = op_a;
                    opnd_b_d = op_b;
                    op_d     = ~start_mult;
`ifdef MULDIV_DIV_ZERO_CHECK_EN
                    if (!start_mult && (op_b == 32'd0)) begin
                        state_d = S_DZERO;
                    end else begin
                        state_d    = S_LAUNCH;
                        mult_rst_d = start_mult;
                        div_rst_d  = ~start_mult;
                    end
`else
                    state_d    = S_LAUNCH;
                    mult_rst_d = start_mult;
                    div_rst_d  = ~start_mult;
`endif
                end
            end
            S_LAUNCH: begin
                cnt_d   = op_q ? DIV_CNT : MULT_CNT;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                hi_d    = op_q ? div_hi : mult_hi;
                lo_d    = op_q ? div_lo : mult_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
`ifdef MULDIV_DIV_ZERO_CHECK_EN
            S_DZERO: begin
                // Hi/Lo deliberately untouched on an aborted divide.
                done_d  = 1'b1;
                dz_d    = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign opnd_a   = opnd_a_q;
    assign opnd_b   = opnd_b_q;
    assign mult_rst = mult_rst_q;
    assign div_rst  = div_rst_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
`ifdef MULDIV_DIV_ZERO_CHECK_EN
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

`default_nettype wire
